// File: rtl/minmax_tracker_pkg.sv
// Shared types for the min/max tracker: FSM state encoding and the
// 2-bit compare codes produced by the sample comparators.
// Imported by minmax_tracker and minmax_tracker_cmp.
package minmax_tracker_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [1:0] cmp_code_t;

  // Compare codes with A as the incoming sample and B as the stored value.
  localparam cmp_code_t CMP_NONE = 2'b00;
  localparam cmp_code_t CMP_EQ   = 2'b01;
  localparam cmp_code_t CMP_GT   = 2'b10;
  localparam cmp_code_t CMP_LT   = 2'b11;

endpackage

// File: rtl/minmax_tracker_cmp.sv
// Purpose: 4-bit unsigned magnitude compare of a against b, as a 2-bit code.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: a, b - unsigned operands; code - CMP_EQ / CMP_GT (a>b) / CMP_LT (a<b).
module minmax_tracker_cmp
  import minmax_tracker_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output cmp_code_t         code
);

  always_comb begin
    if (a == b)     code = CMP_EQ;
    else if (a > b) code = CMP_GT;
    else            code = CMP_LT;
  end

endmodule

// File: rtl/minmax_tracker.sv
// Purpose: tracks max, min, sample count and count-of-max over a set of samples.
// Latency: result valid the cycle after the sample carrying in_last is accepted.
// Backpressure: in_ready drops while a result is pending; held until out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_data/in_last/in_ready sample
//        input handshake; out_valid/out_ready result handshake; out_max,
//        out_min, out_cnt, out_hits registered results (cnt/hits saturate).
module minmax_tracker
  import minmax_tracker_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic [CNT_W-1:0]  out_cnt,
  output logic [CNT_W-1:0]  out_hits
);

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] min_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  hits_q;
  cmp_code_t         max_code;
  cmp_code_t         min_code;
  logic              accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  minmax_tracker_cmp u_cmp_max (
    .a    (in_data),
    .b    (max_q),
    .code (max_code)
  );

  minmax_tracker_cmp u_cmp_min (
    .a    (in_data),
    .b    (min_q),
    .code (min_code)
  );

  assign accept = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DONE : ACCUM;
      ACCUM:   if (accept && in_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only, so no in_* -> out_* path.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      ACCUM:   in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath. accept is only possible in IDLE/ACCUM, so DONE holds results.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q  <= '0;
      min_q  <= '0;
      cnt_q  <= '0;
      hits_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        max_q  <= in_data;
        min_q  <= in_data;
        cnt_q  <= CNT_W'(1);
        hits_q <= CNT_W'(1);
      end else if (state_q == ACCUM &&
                   max_code != CMP_NONE && min_code != CMP_NONE) begin
        // A NONE code would mean a broken comparator; freeze rather than guess.
        cnt_q <= sat_inc(cnt_q);
        case (max_code)
          CMP_GT: begin
            max_q  <= in_data;
            hits_q <= CNT_W'(1);
          end
          CMP_EQ:  hits_q <= sat_inc(hits_q);
          default: ;
        endcase
        if (min_code == CMP_LT) min_q <= in_data;
      end
    end
  end

  assign out_max  = max_q;
  assign out_min  = min_q;
  assign out_cnt  = cnt_q;
  assign out_hits = hits_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker: hand-computed expected results per set.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Runs a fixed number of cycles and ends with a single summary line.
module tb_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_min;
  logic [7:0] out_cnt;
  logic [7:0] out_hits;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  minmax_tracker #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_min   (out_min),
    .out_cnt   (out_cnt),
    .out_hits  (out_hits)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input int mx, input int mn,
                              input int cnt, input int hits);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_rdy"},   32'(in_ready),  32'd0);
    check({tag, "_max"},   32'(out_max),   32'(mx));
    check({tag, "_min"},   32'(out_min),   32'(mn));
    check({tag, "_cnt"},   32'(out_cnt),   32'(cnt));
    check({tag, "_hits"},  32'(out_hits),  32'(hits));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_rdy"},   32'(in_ready),  32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rdy",   32'(in_ready),  32'd1);
    check("rst_max",   32'(out_max),   32'd0);
    check("rst_min",   32'(out_min),   32'd0);
    check("rst_cnt",   32'(out_cnt),   32'd0);
    check("rst_hits",  32'(out_hits),  32'd0);

    // 3,9,1,9 back-to-back
    send(4'd3, 1'b0);
    send(4'd9, 1'b0);
    send(4'd1, 1'b0);
    send(4'd9, 1'b1);
    check_result("set_a", 9, 1, 4, 2);
    drain("set_a");

    // single sample set straight from IDLE
    send(4'd5, 1'b1);
    check_result("single", 5, 5, 1, 1);
    drain("single");

    // 0,15,15,0 then result held with out_ready low and junk on the input
    send(4'd0,  1'b0);
    send(4'd15, 1'b0);
    send(4'd15, 1'b0);
    send(4'd0,  1'b1);
    in_valid = 1'b1;
    in_data  = 4'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_result($sformatf("hold%0d", i), 15, 0, 4, 2);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("hold3", 15, 0, 4, 2);
    drain("hold");

    // new max after repeated equals restarts hits; in_last without valid ignored
    send(4'd5, 1'b0);
    send(4'd5, 1'b0);
    in_last = 1'b1;
    step();
    in_last = 1'b0;
    check("last_novalid_valid", 32'(out_valid), 32'd0);
    check("last_novalid_cnt",   32'(out_cnt),   32'd2);
    send(4'd2, 1'b0);
    send(4'd9, 1'b1);
    check_result("newmax", 9, 2, 4, 1);
    drain("newmax");

    // saturation: 300 samples of 7
    for (int i = 0; i < 300; i++) send(4'd7, (i == 299) ? 1'b1 : 1'b0);
    check_result("sat", 7, 7, 255, 255);
    drain("sat");

    // reset mid-ACCUM discards the partial set
    send(4'd2, 1'b0);
    send(4'd8, 1'b0);
    do_reset();
    check("rst_accum_valid", 32'(out_valid), 32'd0);
    check("rst_accum_cnt",   32'(out_cnt),   32'd0);
    check("rst_accum_max",   32'(out_max),   32'd0);
    send(4'd4, 1'b0);
    send(4'd6, 1'b1);
    check_result("after_rst", 6, 4, 2, 1);

    // reset mid-DONE beats a simultaneous out_ready and drops the result
    out_ready = 1'b1;
    do_reset();
    out_ready = 1'b0;
    check("rst_done_valid", 32'(out_valid), 32'd0);
    check("rst_done_rdy",   32'(in_ready),  32'd1);
    check("rst_done_cnt",   32'(out_cnt),   32'd0);
    check("rst_done_hits",  32'(out_hits),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
